lcd_timing_gen: RTL

Video timing generator for the parallel RGB LCD path. It sits directly downstream of the LCD pixel FIFO. It drives the FIFO read strobe (`active_video_o`) and takes the FIFO's registered pixel word back. It produces panel-aligned `hsync`/`vsync`/`de`/data, with all pins registered and pipelined to the FIFO's one-cycle read latency. Frame start and stop are gated cleanly on frame boundaries by `enable_i`.

---
 rtl/lcd_timing_pkg.sv | 24 ++
 rtl/lcd_sync_counter.sv | 39 +++
 rtl/lcd_timing_gen.sv | 137 +++++++++++++
 3 files changed

// File: rtl/lcd_timing_pkg.sv
// Shared types and default 480x272 panel timing for the LCD timing generator.
package lcd_timing_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } lcd_tg_state_e;

  localparam int unsigned DefHActive = 480;
  localparam int unsigned DefHFp     = 2;
  localparam int unsigned DefHSync   = 41;
  localparam int unsigned DefHBp     = 2;
  localparam int unsigned DefVActive = 272;
  localparam int unsigned DefVFp     = 2;
  localparam int unsigned DefVSync   = 10;
  localparam int unsigned DefVBp     = 2;

  function automatic int unsigned tg_total(input int unsigned sync, input int unsigned bp,
                                           input int unsigned act, input int unsigned fp);
    return sync + bp + act + fp;
  endfunction

endpackage

// File: rtl/lcd_sync_counter.sv
// One timing axis: wrapping position counter with sync/active region decode.
module lcd_sync_counter
  import lcd_timing_pkg::*;
#(
  parameter int unsigned SYNC = 2,
  parameter int unsigned BP   = 1,
  parameter int unsigned ACT  = 4,
  parameter int unsigned FP   = 1,
  parameter int unsigned W    = $clog2(tg_total(SYNC, BP, ACT, FP))
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         adv,
  output logic [W-1:0] cnt,
  output logic         sync,
  output logic         act,
  output logic         last
);

  localparam int unsigned Total = tg_total(SYNC, BP, ACT, FP);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt_q <= '0;
    end else if (adv) begin
      cnt_q <= last ? '0 : cnt_q + W'(1);
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == W'(Total - 1));
  assign sync = (cnt_q < W'(SYNC));
  // Active end may equal Total (no front porch), so compare with one spare bit.
  assign act  = (cnt_q >= W'(SYNC + BP)) && ({1'b0, cnt_q} < (W + 1)'(SYNC + BP + ACT));

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD video timing generator: frame-gated FSM, axis counters and 2-stage pin pipeline
// aligned to the pixel FIFO's one-cycle read latency.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned H_ACTIVE   = DefHActive,
  parameter int unsigned H_FP       = DefHFp,
  parameter int unsigned H_SYNC     = DefHSync,
  parameter int unsigned H_BP       = DefHBp,
  parameter int unsigned V_ACTIVE   = DefVActive,
  parameter int unsigned V_FP       = DefVFp,
  parameter int unsigned V_SYNC     = DefVSync,
  parameter int unsigned V_BP       = DefVBp,
  parameter bit          HSYNC_POL  = 1'b0,
  parameter bit          VSYNC_POL  = 1'b0
) (
  input  logic                  aclk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  output logic                  active_video_o,
  input  logic [DATA_WIDTH-1:0] lcd_dat_i,
  output logic                  lcd_hsync_o,
  output logic                  lcd_vsync_o,
  output logic                  lcd_de_o,
  output logic [DATA_WIDTH-1:0] lcd_dat_o,
  output logic                  frame_start_o,
  output logic                  busy_o
);

  localparam int unsigned HW = $clog2(tg_total(H_SYNC, H_BP, H_ACTIVE, H_FP));
  localparam int unsigned VW = $clog2(tg_total(V_SYNC, V_BP, V_ACTIVE, V_FP));

  lcd_tg_state_e state_q, state_d;

  logic          running;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_sync, h_act, h_last;
  logic          v_sync, v_act, v_last;

  assign running = (state_q != IDLE);

  lcd_sync_counter #(
    .SYNC (H_SYNC),
    .BP   (H_BP),
    .ACT  (H_ACTIVE),
    .FP   (H_FP),
    .W    (HW)
  ) u_h_cnt (
    .clk   (aclk_i),
    .rst_n (rst_ni),
    .clr   (!running),
    .adv   (running),
    .cnt   (h_cnt),
    .sync  (h_sync),
    .act   (h_act),
    .last  (h_last)
  );

  lcd_sync_counter #(
    .SYNC (V_SYNC),
    .BP   (V_BP),
    .ACT  (V_ACTIVE),
    .FP   (V_FP),
    .W    (VW)
  ) u_v_cnt (
    .clk   (aclk_i),
    .rst_n (rst_ni),
    .clr   (!running),
    .adv   (running && h_last),
    .cnt   (v_cnt),
    .sync  (v_sync),
    .act   (v_act),
    .last  (v_last)
  );

  always_ff @(posedge aclk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // STOP only retires on the last pixel of the frame, so frames are never truncated.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable_i) state_d = RUN;
      RUN:     if (!enable_i) state_d = STOP;
      STOP: begin
        if (enable_i) begin
          state_d = RUN;
        end else if (h_last && v_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign active_video_o = h_act && v_act && running;
  assign frame_start_o  = running && (h_cnt == '0) && (v_cnt == '0);
  assign busy_o         = running;

  logic                  hs_s1_q, vs_s1_q, de_s1_q;
  logic                  hsync_q, vsync_q, de_q;
  logic [DATA_WIDTH-1:0] dat_q;

  // Stage 1 holds active-high decodes; stage 2 applies pin polarity and captures FIFO data.
  always_ff @(posedge aclk_i) begin
    if (!rst_ni) begin
      hs_s1_q <= 1'b0;
      vs_s1_q <= 1'b0;
      de_s1_q <= 1'b0;
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      de_q    <= 1'b0;
      dat_q   <= '0;
    end else begin
      hs_s1_q <= running && h_sync;
      vs_s1_q <= running && v_sync;
      de_s1_q <= active_video_o;
      hsync_q <= hs_s1_q ? HSYNC_POL : ~HSYNC_POL;
      vsync_q <= vs_s1_q ? VSYNC_POL : ~VSYNC_POL;
      de_q    <= de_s1_q;
      dat_q   <= de_s1_q ? lcd_dat_i : '0;
    end
  end

  assign lcd_hsync_o = hsync_q;
  assign lcd_vsync_o = vsync_q;
  assign lcd_de_o    = de_q;
  assign lcd_dat_o   = dat_q;

endmodule
